mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Initiator-side controller for the 2-read/1-write synchronous byte RAM (`ram`).
- Port 1 serves a read-only instruction-fetch channel.
- Port 2 serves a data channel with byte/word loads and stores.
- Word accesses are split by an FSM into two consecutive byte accesses, little-endian.
- Sits between the CPU core and `ram` and absorbs the RAM's one-cycle registered read latency.

Parameters:
ADDR_W, 8, RAM address width (256 bytes)
DATA_W, 8, RAM byte width; word = 2*DATA_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
f_req_valid  in  1  fetch request; always accepted outside reset
f_req_addr  in  ADDR_W  fetch byte address
f_rsp_valid  out  1  fetch data valid
f_rsp_data  out  DATA_W  fetched byte
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted when valid&ready
d_req_we  in  1  1=store, 0=load
d_req_word  in  1  1=16-bit access, 0=byte
d_req_addr  in  ADDR_W  data byte address (low byte of word)
d_req_wdata  in  2*DATA_W  store data; byte store uses [7:0]
d_rsp_valid  out  1  load data / store ack, one-cycle pulse, no backpressure
d_rsp_rdata  out  2*DATA_W  load result; 0 for store acks
ram_addr_1  out  ADDR_W  to ram addr_in_port_1
ram_rdata_1  in  DATA_W  from ram data_out_port_1
ram_addr_2  out  ADDR_W  to ram addr_in_port_2
ram_wdata  out  DATA_W  to ram write data
ram_we  out  1  to ram write_en
ram_rdata_2  in  DATA_W  from ram data_out_port_2

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE; f_rsp_valid=0; d_rsp_valid=0.
- Latched addr, hi-byte and lo-byte registers cleared; rsp_is_word=0, rsp_is_wr=0.
- d_req_ready=0 and ram_we=0 while reset is low; requests are ignored.

Fetch channel:
- ram_addr_1 = f_req_addr, combinational.
- f_rsp_valid is registered f_req_valid, so latency = 1 cycle.
- f_rsp_data = ram_rdata_1, passthrough.
- Back-to-back fetches are accepted every cycle.

Data FSM states: IDLE, RD_HI, WR_HI.
IDLE:
- d_req_ready=1; ram_addr_2=d_req_addr; ram_we=d_req_valid&d_req_we; ram_wdata=d_req_wdata[7:0].
- On accept: latch addr+1 (mod 2^ADDR_W, so 8'hFF wraps to 8'h00) and d_req_wdata[15:8].
- byte load or byte store: stay in IDLE; d_rsp_valid=1 next cycle.
- word load: go to RD_HI.
- word store: go to WR_HI.
RD_HI:
- d_req_ready=0; ram_addr_2=latched addr+1; ram_we=0.
- At the clock edge, capture ram_rdata_2 (the low byte) into the lo register, then return to IDLE with d_rsp_valid=1.
WR_HI:
- d_req_ready=0; ram_addr_2=latched addr+1; ram_wdata=latched hi byte; ram_we=1.
- Return to IDLE with d_rsp_valid=1.
d_rsp_rdata in the response cycle:
- byte load: {8'h00, ram_rdata_2}
- word load: {ram_rdata_2, lo_reg}
- store: 16'h0000
Latency and throughput:
- Byte access: accept cycle N, response at N+1.
- Word access: response at N+2.
- In the response cycle the FSM is in IDLE, so a new request may be accepted in the same cycle.
- Sustained rate: one byte op per cycle; one word op per 2 cycles.
Boundary and hazard rules:
- Write/fetch collision: a fetch to the address being written in the same cycle returns the old byte (RAM read-before-write). No forwarding.
- Store followed by a load to the same address in the next cycle returns the new data.
- Reset mid-operation in WR_HI: low byte is already written, high byte is not written, no ack.
- Reset mid-operation in RD_HI: the load is dropped with no response.
- A requester that sees d_req_ready=0 must hold its request; nothing is accepted.

Test Plan:
- Preload mem[0x10]=0xA5 and mem[0x11]=0x3C. Fetch 0x10 and 0x11 on consecutive cycles -> f_rsp_valid for 2 cycles, data 0xA5 then 0x3C, each 1 cycle after its request.
- Word store 0xBEEF at 0x20 -> ram_we high for 2 cycles (addr 0x20 data 0xEF, then addr 0x21 data 0xBE); d_req_ready=0 in the 2nd cycle; ack at N+2 with rdata 0x0000. Word load 0x20 then returns 0xBEEF at N+2.
- Word load at 0xFF with mem[0xFF]=0x12 and mem[0x00]=0x34 -> high byte address wraps to 0x00; d_rsp_rdata=0x3412.
- Byte store 0x77 to 0x40 while fetching 0x40 in the same cycle -> fetch returns the old value 0x00. Byte load 0x40 next cycle -> 0x0077.
- Issue a word store at 0x50, and pull reset low while the FSM is in WR_HI -> mem[0x50] updated, mem[0x51] unchanged, no d_rsp_valid, all outputs at reset values immediately (asynchronous).
- Back-to-back: byte load, word load, byte store with valid held high -> ready pattern 1,1,0,1; responses at cycles 1, 3, 4.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// CPU-side bus of the RAM controller: fetch channel plus data channel.
// Pure wiring, no latency of its own.
// Fetch has no backpressure; data requests are flow-controlled by d_req_ready.
interface mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // fetch channel
  logic                  f_req_valid;
  logic [ADDR_W-1:0]     f_req_addr;
  logic                  f_rsp_valid;
  logic [DATA_W-1:0]     f_rsp_data;
  // data channel
  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_req_we;
  logic                  d_req_word;
  logic [ADDR_W-1:0]     d_req_addr;
  logic [2*DATA_W-1:0]   d_req_wdata;
  logic                  d_rsp_valid;
  logic [2*DATA_W-1:0]   d_rsp_rdata;

  // CPU side
  modport master (
    output f_req_valid, f_req_addr, d_req_valid, d_req_we, d_req_word,
           d_req_addr, d_req_wdata,
    input  f_rsp_valid, f_rsp_data, d_req_ready, d_rsp_valid, d_rsp_rdata
  );

  // controller side
  modport slave (
    input  f_req_valid, f_req_addr, d_req_valid, d_req_we, d_req_word,
           d_req_addr, d_req_wdata,
    output f_rsp_valid, f_rsp_data, d_req_ready, d_rsp_valid, d_rsp_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Controller for a 2-read/1-write byte RAM: fetch on port 1, byte/word loads and stores on port 2.
// Fetch and byte ops respond 1 cycle after accept, word ops 2 cycles (split into lo/hi byte, little-endian).
// Fetch is never stalled; d_req_ready drops for the second half of a word op; responses cannot be stalled.
module mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] ram_addr_1,
  input  logic [DATA_W-1:0] ram_rdata_1,
  output logic [ADDR_W-1:0] ram_addr_2,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata_2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_HI = 2'd1,
    WR_HI = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_hi;      // address of the high byte of a word op
  logic [DATA_W-1:0]   hi_byte;      // high byte of a pending word store
  logic [DATA_W-1:0]   lo_byte;      // low byte captured during a word load
  logic                rsp_is_word;
  logic                rsp_is_wr;
  logic                f_vld_q;
  logic                d_vld_q;
  logic                d_vld_nxt;
  logic                req_rdy;
  logic                accept;
  logic [2*DATA_W-1:0] rsp_rdata;

  // Fetch path: address straight through, RAM's registered read supplies the 1-cycle latency.
  assign ram_addr_1      = bus.f_req_addr;
  assign bus.f_rsp_data  = ram_rdata_1;
  assign bus.f_rsp_valid = f_vld_q;

  assign bus.d_req_ready = req_rdy;
  assign bus.d_rsp_valid = d_vld_q;
  assign bus.d_rsp_rdata = rsp_rdata;
  assign accept          = bus.d_req_valid & req_rdy;

  // State register for the word-splitting FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and RAM port 2 drive; reset forces ready and write-enable low immediately.
  always_comb begin
    state_nxt  = state;
    req_rdy    = 1'b0;
    ram_addr_2 = addr_hi;
    ram_wdata  = hi_byte;
    ram_we     = 1'b0;
    d_vld_nxt  = 1'b0;
    case (state)
      IDLE: begin
        req_rdy    = 1'b1;
        ram_addr_2 = bus.d_req_addr;
        ram_wdata  = bus.d_req_wdata[DATA_W-1:0];
        ram_we     = bus.d_req_valid & bus.d_req_we;
        if (bus.d_req_valid) begin
          if (!bus.d_req_word) begin
            d_vld_nxt = 1'b1;
          end else if (bus.d_req_we) begin
            state_nxt = WR_HI;
          end else begin
            state_nxt = RD_HI;
          end
        end
      end
      RD_HI: begin
        state_nxt = IDLE;
        d_vld_nxt = 1'b1;
      end
      WR_HI: begin
        ram_we    = 1'b1;
        state_nxt = IDLE;
        d_vld_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!reset) begin
      req_rdy = 1'b0;
      ram_we  = 1'b0;
    end
  end

  // Response valids: fetch echoes the request one cycle later, data follows the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
    end else begin
      f_vld_q <= bus.f_req_valid;
      d_vld_q <= d_vld_nxt;
    end
  end

  // Request context: high-byte address and data latched on accept, low byte captured in RD_HI.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_hi     <= '0;
      hi_byte     <= '0;
      lo_byte     <= '0;
      rsp_is_word <= 1'b0;
      rsp_is_wr   <= 1'b0;
    end else begin
      if (accept) begin
        addr_hi     <= bus.d_req_addr + ADDR_ONE;
        hi_byte     <= bus.d_req_wdata[2*DATA_W-1:DATA_W];
        rsp_is_word <= bus.d_req_word;
        rsp_is_wr   <= bus.d_req_we;
      end
      if (state == RD_HI) begin
        lo_byte <= ram_rdata_2;
      end
    end
  end

  // Load data assembly: the RAM output in the response cycle is the last byte read.
  always_comb begin
    rsp_rdata = '0;
    if (d_vld_q && !rsp_is_wr) begin
      if (rsp_is_word) begin
        rsp_rdata = {ram_rdata_2, lo_byte};
      end else begin
        rsp_rdata = {{DATA_W{1'b0}}, ram_rdata_2};
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural read-before-write RAM, scoreboard queues for fetch and data responses.
// Responses are checked for data and exact arrival cycle; tasks check handshake and RAM-side signals inline.
// Every wait on the DUT is bounded.
module tb_mem_ctrl;

  typedef struct {
    logic [15:0] data;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t f_q[$];
  exp_t d_q[$];

  logic [7:0] ram_addr_1, ram_addr_2, ram_wdata, ram_rdata_1, ram_rdata_2;
  logic       ram_we;
  logic [7:0] ram_mem [256];
  logic       bd_clr, bd_we;
  logic [7:0] bd_addr, bd_data;

  mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .ram_addr_1  (ram_addr_1),
    .ram_rdata_1 (ram_rdata_1),
    .ram_addr_2  (ram_addr_2),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata_2 (ram_rdata_2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: registered reads see the pre-write contents; backdoor port for preload.
  always @(posedge clk) begin
    ram_rdata_1 <= ram_mem[ram_addr_1];
    ram_rdata_2 <= ram_mem[ram_addr_2];
    if (bd_clr) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
    end else if (bd_we) begin
      ram_mem[bd_addr] <= bd_data;
    end else if (ram_we) begin
      ram_mem[ram_addr_2] <= ram_wdata;
    end
  end

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.f_rsp_valid === 1'b1) begin
        checks++;
        if (f_q.size() == 0) begin
          errors++;
          $display("FAIL fetch_unexpected: response data %h at cycle %0d, none expected", bus.f_rsp_data, cyc);
        end else begin
          e = f_q.pop_front();
          if (bus.f_rsp_data !== e.data[7:0] || cyc != e.at) begin
            errors++;
            $display("FAIL fetch_rsp: got %h at cycle %0d, expected %h at cycle %0d", bus.f_rsp_data, cyc, e.data[7:0], e.at);
          end
        end
      end
      if (bus.d_rsp_valid === 1'b1) begin
        checks++;
        if (d_q.size() == 0) begin
          errors++;
          $display("FAIL data_unexpected: response %h at cycle %0d, none expected", bus.d_rsp_rdata, cyc);
        end else begin
          e = d_q.pop_front();
          if (bus.d_rsp_rdata !== e.data || cyc != e.at) begin
            errors++;
            $display("FAIL data_rsp: got %h at cycle %0d, expected %h at cycle %0d", bus.d_rsp_rdata, cyc, e.data, e.at);
          end
        end
      end
    end
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while ((f_q.size() != 0 || d_q.size() != 0) && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    ok = (f_q.size() == 0 && d_q.size() == 0);
    f_q.delete();
    d_q.delete();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic d_idle();
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_req_word = 1'b0;
    bus.d_req_addr = 8'h00; bus.d_req_wdata = 16'h0000;
  endtask

  task automatic d_drive(input logic we, input logic word, input logic [7:0] a, input logic [15:0] wd);
    bus.d_req_valid = 1'b1; bus.d_req_we = we; bus.d_req_word = word;
    bus.d_req_addr = a; bus.d_req_wdata = wd;
  endtask

  task automatic test_reset();
    @(negedge clk);
    d_drive(1'b1, 1'b0, 8'h05, 16'h1234);
    @(negedge clk);
    #1;
    checks++;
    if (bus.f_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: f=%b d=%b, expected 0 0", bus.f_rsp_valid, bus.d_rsp_valid);
    end
    checks++;
    if (bus.d_req_ready !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_we: ready=%b we=%b, expected 0 0", bus.d_req_ready, ram_we);
    end
    @(negedge clk);
    d_idle();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, expected 1", bus.d_req_ready);
    end
    checks++;
    if (ram_mem[8'h05] !== 8'h00) begin
      errors++;
      $display("FAIL reset_ignored_store: mem[05]=%h, expected 00", ram_mem[8'h05]);
    end
  endtask

  task automatic test_fetch();
    bit ok;
    @(negedge clk);
    bus.f_req_valid = 1'b1; bus.f_req_addr = 8'h10;
    f_q.push_back('{data: 16'h00A5, at: cyc + 1});
    #1;
    checks++;
    if (ram_addr_1 !== 8'h10) begin
      errors++;
      $display("FAIL fetch_addr: ram_addr_1=%h, expected 10", ram_addr_1);
    end
    @(negedge clk);
    bus.f_req_addr = 8'h11;
    f_q.push_back('{data: 16'h003C, at: cyc + 1});
    @(negedge clk);
    bus.f_req_valid = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fetch_drain: responses missing, expected all delivered"); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.f_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_valid_drop: f_rsp_valid=%b, expected 0", bus.f_rsp_valid);
    end
  endtask

  task automatic test_word_store();
    bit ok;
    @(negedge clk);
    d_drive(1'b1, 1'b1, 8'h20, 16'hBEEF);
    d_q.push_back('{data: 16'h0000, at: cyc + 2});
    #1;
    checks++;
    if (bus.d_req_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr_2 !== 8'h20 || ram_wdata !== 8'hEF) begin
      errors++;
      $display("FAIL wstore_lo: rdy=%b we=%b addr=%h data=%h, expected 1 1 20 ef", bus.d_req_ready, ram_we, ram_addr_2, ram_wdata);
    end
    @(negedge clk);
    d_idle();
    #1;
    checks++;
    if (bus.d_req_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr_2 !== 8'h21 || ram_wdata !== 8'hBE) begin
      errors++;
      $display("FAIL wstore_hi: rdy=%b we=%b addr=%h data=%h, expected 0 1 21 be", bus.d_req_ready, ram_we, ram_addr_2, ram_wdata);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wstore_drain: ack missing, expected one ack"); end
    checks++;
    if (ram_mem[8'h20] !== 8'hEF || ram_mem[8'h21] !== 8'hBE) begin
      errors++;
      $display("FAIL wstore_mem: mem[20]=%h mem[21]=%h, expected ef be", ram_mem[8'h20], ram_mem[8'h21]);
    end
    @(negedge clk);
    d_drive(1'b0, 1'b1, 8'h20, 16'h0000);
    d_q.push_back('{data: 16'hBEEF, at: cyc + 2});
    @(negedge clk);
    d_idle();
    #1;
    checks++;
    if (bus.d_req_ready !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL wload_hi: rdy=%b we=%b, expected 0 0", bus.d_req_ready, ram_we);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wload_drain: load response missing, expected beef"); end
  endtask

  task automatic test_wrap();
    bit ok;
    @(negedge clk);
    d_drive(1'b0, 1'b1, 8'hFF, 16'h0000);
    d_q.push_back('{data: 16'h3412, at: cyc + 2});
    @(negedge clk);
    d_idle();
    #1;
    checks++;
    if (ram_addr_2 !== 8'h00) begin
      errors++;
      $display("FAIL wrap_addr: ram_addr_2=%h, expected 00", ram_addr_2);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_drain: load response missing, expected 3412"); end
  endtask

  task automatic test_collision();
    bit ok;
    @(negedge clk);
    bus.f_req_valid = 1'b1; bus.f_req_addr = 8'h40;
    d_drive(1'b1, 1'b0, 8'h40, 16'h0077);
    f_q.push_back('{data: 16'h0000, at: cyc + 1});
    d_q.push_back('{data: 16'h0000, at: cyc + 1});
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_wdata !== 8'h77) begin
      errors++;
      $display("FAIL coll_store: we=%b data=%h, expected 1 77", ram_we, ram_wdata);
    end
    @(negedge clk);
    bus.f_req_valid = 1'b0;
    d_drive(1'b0, 1'b0, 8'h40, 16'h0000);
    d_q.push_back('{data: 16'h0077, at: cyc + 1});
    #1;
    checks++;
    if (bus.d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_ready: ready=%b in ack cycle, expected 1", bus.d_req_ready);
    end
    @(negedge clk);
    d_idle();
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL coll_drain: responses missing, expected all delivered"); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_drive(1'b1, 1'b1, 8'h50, 16'hCAFE);
    @(negedge clk);
    d_idle();
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_addr_2 !== 8'h51) begin
      errors++;
      $display("FAIL rmid_in_wr_hi: we=%b addr=%h, expected 1 51", ram_we, ram_addr_2);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || bus.d_req_ready !== 1'b0 || bus.d_rsp_valid !== 1'b0 || bus.f_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: we=%b rdy=%b dv=%b fv=%b, expected 0 0 0 0", ram_we, bus.d_req_ready, bus.d_rsp_valid, bus.f_rsp_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ram_mem[8'h50] !== 8'hFE || ram_mem[8'h51] !== 8'h99) begin
      errors++;
      $display("FAIL rmid_mem: mem[50]=%h mem[51]=%h, expected fe 99", ram_mem[8'h50], ram_mem[8'h51]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_release: ready=%b, expected 1", bus.d_req_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k = 0;
    int c0;
    logic [3:0] exp_rdy = 4'b1011;
    @(negedge clk);
    c0 = cyc;
    d_q.push_back('{data: 16'h0011, at: c0 + 1});
    d_q.push_back('{data: 16'h3322, at: c0 + 3});
    d_q.push_back('{data: 16'h0000, at: c0 + 4});
    for (int i = 0; i < 4; i++) begin
      case (k)
        0:       d_drive(1'b0, 1'b0, 8'h60, 16'h0000);
        1:       d_drive(1'b0, 1'b1, 8'h61, 16'h0000);
        default: d_drive(1'b1, 1'b0, 8'h70, 16'h55AA);
      endcase
      #1;
      checks++;
      if (bus.d_req_ready !== exp_rdy[i]) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b, expected %b", i, bus.d_req_ready, exp_rdy[i]);
      end
      if (bus.d_req_ready === 1'b1) k++;
      @(negedge clk);
    end
    d_idle();
    wait_drain(ok);
    checks++;
    if (!ok || k != 3) begin
      errors++;
      $display("FAIL b2b_drain: accepted %0d ops, drained=%0d, expected 3 accepted and drained", k, ok);
    end
    checks++;
    if (ram_mem[8'h70] !== 8'hAA) begin
      errors++;
      $display("FAIL b2b_store: mem[70]=%h, expected aa", ram_mem[8'h70]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.f_req_valid = 1'b0;
    bus.f_req_addr = 8'h00;
    d_idle();
    bd_clr = 1'b1; bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
    fork
      monitor();
    join_none
    @(negedge clk);
    bd_clr = 1'b0;
    preload(8'h10, 8'hA5);
    preload(8'h11, 8'h3C);
    preload(8'hFF, 8'h12);
    preload(8'h00, 8'h34);
    preload(8'h51, 8'h99);
    preload(8'h60, 8'h11);
    preload(8'h61, 8'h22);
    preload(8'h62, 8'h33);
    test_reset();
    test_fetch();
    test_word_store();
    test_wrap();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
